ht16k33_target: RTL and testbench

HT16K33_TARGET -- requirements
Module: ht16k33_target

---
 rtl/ht16k33_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 42 ++++
 rtl/ht16k33_target.sv | 222 ++++++++++++++++++++++
 tb/tb_ht16k33_target.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ht16k33_pkg.sv
// Shared constants for the HT16K33-style I2C target and its master-side driver.
package ht16k33_pkg;

    localparam logic [6:0] DefaultAddr = 7'h70;

    // Upper nibble of a command byte
    localparam logic [3:0] CmdRamPtr = 4'h0;
    localparam logic [3:0] CmdOsc    = 4'h2;
    localparam logic [3:0] CmdDisp   = 4'h8;
    localparam logic [3:0] CmdDim    = 4'hE;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StCmd,
        StData,
        StWrAck,
        StRdByte,
        StRdAck,
        StIgnore
    } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP detection.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic bus_start,
    output logic bus_stop
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl       = scl_sync_q[1];
    assign sda       = sda_sync_q[1];
    assign scl_rise  = scl & ~scl_prev_q;
    assign scl_fall  = ~scl & scl_prev_q;
    // SDA may only move while SCL is high for a START/STOP
    assign bus_start = scl & scl_prev_q & sda_prev_q & ~sda;
    assign bus_stop  = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/ht16k33_target.sv
// I2C target for an HT16K33-style display controller: command decode and 16x8 display RAM.
module ht16k33_target
    import ht16k33_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DefaultAddr
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       osc_on,
    output logic       disp_on,
    output logic [1:0] blink,
    output logic [3:0] dim,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cmd_stb
);

    logic sda, scl_rise, scl_fall, bus_start, bus_stop;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .bus_start(bus_start),
        .bus_stop (bus_stop)
    );

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [3:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic       osc_q, osc_d;
    logic       disp_q, disp_d;
    logic [1:0] blink_q, blink_d;
    logic [3:0] dim_q, dim_d;
    logic       stb_q, stb_d;
    logic       to_data_q, to_data_d;
    logic       ram_we;
    logic [7:0] ram_q [16];

    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic       byte_done;

    assign rx_byte   = {rx_q, sda};
    assign rd_byte   = ram_q[ptr_q];
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        osc_d     = osc_q;
        disp_d    = disp_q;
        blink_d   = blink_q;
        dim_d     = dim_q;
        to_data_d = to_data_q;
        stb_d     = 1'b0;
        ram_we    = 1'b0;

        if (bus_stop || bus_start) begin
            // Any partial byte is dropped; nothing is committed before the 8th bit
            state_d   = bus_start ? StAddr : StIdle;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            if (scl_rise && (state_q inside {StAddr, StCmd, StData})) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = byte_done ? 4'd0 : bit_cnt_q + 4'd1;
            end
            unique case (state_q)
                StIdle, StIgnore: ;
                StAddr: begin
                    if (byte_done) state_d = (rx_byte[7:1] == DEV_ADDR) ? StAddrAck : StIgnore;
                end
                StCmd: begin
                    if (byte_done) begin
                        stb_d     = 1'b1;
                        state_d   = StWrAck;
                        to_data_d = 1'b0;
                        case (rx_byte[7:4])
                            CmdRamPtr: begin
                                ptr_d     = rx_byte[3:0];
                                to_data_d = 1'b1;
                            end
                            CmdOsc:  if (rx_byte[3:1] == 3'b000) osc_d = rx_byte[0];
                            CmdDisp: begin
                                if (!rx_byte[3]) begin
                                    disp_d  = rx_byte[0];
                                    blink_d = rx_byte[2:1];
                                end
                            end
                            CmdDim:  dim_d = rx_byte[3:0];
                            default: ;
                        endcase
                    end
                end
                StData: begin
                    if (byte_done) begin
                        ram_we  = 1'b1;
                        ptr_d   = ptr_q + 4'd1;
                        state_d = StWrAck;
                    end
                end
                // bit_cnt 0: ACK not yet driven; 1: ACK on the bus
                StAddrAck: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else if (rx_q[0]) begin
                            tx_d      = rd_byte;
                            sda_oe_d  = ~rd_byte[7];
                            bit_cnt_d = 4'd0;
                            state_d   = StRdByte;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = StCmd;
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = to_data_q ? StData : StCmd;
                        end
                    end
                end
                StRdByte: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StRdAck;
                    end else if (scl_fall && (bit_cnt_q != 4'd0)) begin
                        tx_d     = tx_q << 1;
                        sda_oe_d = ~tx_d[7];
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_d = StIgnore;
                        end else begin
                            ptr_d     = ptr_q + 4'd1;
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
                        tx_d      = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 4'd0;
                        state_d   = StRdByte;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            rx_q      <= 7'd0;
            tx_q      <= 8'd0;
            ptr_q     <= 4'd0;
            sda_oe_q  <= 1'b0;
            osc_q     <= 1'b0;
            disp_q    <= 1'b0;
            blink_q   <= 2'b00;
            dim_q     <= 4'hF;
            stb_q     <= 1'b0;
            to_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            osc_q     <= osc_d;
            disp_q    <= disp_d;
            blink_q   <= blink_d;
            dim_q     <= dim_d;
            stb_q     <= stb_d;
            to_data_q <= to_data_d;
        end
    end

    // Display RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ptr_q] <= rx_byte;
    end

    assign rd_data = ram_q[rd_addr];
    assign sda_oe  = sda_oe_q;
    assign osc_on  = osc_q;
    assign disp_on = disp_q;
    assign blink   = blink_q;
    assign dim     = dim_q;
    assign cmd_stb = stb_q;

endmodule

// File: tb/tb_ht16k33_target.sv
// Bench for ht16k33_target: bit-banged I2C master against a transaction-level model.
module tb_ht16k33_target;

    localparam int unsigned QCyc = 5;
    localparam logic [6:0]  Addr = 7'h70;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m, sda_bus;
    logic       sda_oe, osc_on, disp_on, cmd_stb;
    logic [1:0] blink;
    logic [3:0] dim, rd_addr;
    logic [7:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;
    int stb_count = 0;

    logic [7:0] mram [16];
    bit         mvalid [16];
    logic [3:0] m_ptr;
    logic       m_osc, m_disp;
    logic [1:0] m_blink;
    logic [3:0] m_dim;
    int         m_stb = 0;
    logic [7:0] txq [$];
    logic [7:0] rxq [$];

    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;
    always @(posedge clk) if (cmd_stb === 1'b1) stb_count <= stb_count + 1;

    ht16k33_target #(.DEV_ADDR(Addr)) dut (
        .clk    (clk),
        .rst    (rst),
        .scl_in (scl_m),
        .sda_in (sda_bus),
        .sda_oe (sda_oe),
        .osc_on (osc_on),
        .disp_on(disp_on),
        .blink  (blink),
        .dim    (dim),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .cmd_stb(cmd_stb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic qw();
        repeat (QCyc) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = 4'd0; m_osc = 1'b0; m_disp = 1'b0; m_blink = 2'b00; m_dim = 4'hF;
    endtask

    // Command bytes are decoded until a RAM-pointer command; after that every byte is data
    task automatic model_write();
        bit data_mode = 1'b0;
        foreach (txq[i]) begin
            if (!data_mode) begin
                m_stb++;
                if (txq[i] < 8'h10) begin
                    m_ptr = txq[i][3:0];
                    data_mode = 1'b1;
                end else if (txq[i] == 8'h20 || txq[i] == 8'h21) begin
                    m_osc = txq[i][0];
                end else if (txq[i] >= 8'h80 && txq[i] <= 8'h87) begin
                    m_disp  = txq[i][0];
                    m_blink = txq[i][2:1];
                end else if (txq[i] >= 8'hE0) begin
                    m_dim = txq[i][3:0];
                end
            end else begin
                mram[m_ptr]   = txq[i];
                mvalid[m_ptr] = 1'b1;
                m_ptr = 4'((m_ptr + 1) % 16);
            end
        end
    endtask

    task automatic check_all();
        check("sda_idle", sda_oe, 1'b0);
        check("osc_on", osc_on, m_osc);
        check("disp_on", disp_on, m_disp);
        check("blink", blink, m_blink);
        check("dim", dim, m_dim);
        check("cmd_stb_count", stb_count, m_stb);
        for (int a = 0; a < 16; a++) begin
            if (mvalid[a]) begin
                rd_addr = 4'(a);
                #1;
                check($sformatf("ram[%0d]", a), rd_data, mram[a]);
            end
        end
    endtask

    task automatic start_cond();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1; qw();
            scl_m = 1'b1; qw();
        end
        sda_m = 1'b0; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b1; qw(); qw();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; qw();
        scl_m = 1'b1; qw(); qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        b = sda_bus; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic do_write(input logic [6:0] a);
        logic ack;
        logic hit;
        hit = (a == Addr);
        start_cond();
        write_byte({a, 1'b0}, ack);
        check("addr_ack", ack, hit);
        foreach (txq[i]) begin
            write_byte(txq[i], ack);
            check("byte_ack", ack, hit);
        end
        stop_cond();
        if (hit) model_write();
        check_all();
    endtask

    task automatic do_read(input int n, input bit set_ptr, input logic [3:0] p);
        logic       ack;
        logic [7:0] d;
        rxq.delete();
        start_cond();
        if (set_ptr) begin
            write_byte({Addr, 1'b0}, ack);
            check("rd_waddr_ack", ack, 1'b1);
            write_byte({4'h0, p}, ack);
            check("rd_ptr_ack", ack, 1'b1);
            m_ptr = p;
            m_stb++;
            start_cond();
        end
        write_byte({Addr, 1'b1}, ack);
        check("rd_addr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte(d, i < n - 1);
            rxq.push_back(d);
            if (mvalid[m_ptr]) check("rd_byte", d, mram[m_ptr]);
            if (i < n - 1) m_ptr = 4'((m_ptr + 1) % 16);
        end
        check("rd_nack_release", sda_oe, 1'b0);
        stop_cond();
        check_all();
    endtask

    function automatic logic [7:0] rand_cmd();
        logic [7:0] c;
        case ($urandom_range(0, 3))
            0:       c = {7'h10, 1'($urandom)};
            1:       c = {5'h10, 3'($urandom)};
            2:       c = {4'hE, 4'($urandom)};
            default: c = 8'($urandom_range(16, 255));
        endcase
        return c;
    endfunction

    initial begin
        int         s0, kind, n;
        logic       ack, b;
        logic [3:0] p;
        logic [7:0] d, hdr;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
        model_reset();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_osc", osc_on, 1'b0);
        check("rst_disp", disp_on, 1'b0);
        check("rst_blink", blink, 2'b00);
        check("rst_dim", dim, 4'hF);
        check("rst_stb", cmd_stb, 1'b0);
        rst = 1'b0;
        qw();

        // Oscillator on
        s0 = stb_count;
        txq = '{8'h21};
        do_write(Addr);
        check("osc_set", osc_on, 1'b1);
        check("one_stb", stb_count - s0, 1);

        // Display on, blink off, dim 7
        txq = '{8'h81, 8'hE7};
        do_write(Addr);
        check("disp_set", disp_on, 1'b1);
        check("blink_set", blink, 2'b00);
        check("dim_set", dim, 4'h7);

        // RAM burst wrapping past 0xF
        txq = '{8'h0E, 8'hAA, 8'h55, 8'h11};
        do_write(Addr);
        rd_addr = 4'hE; #1; check("ram_e", rd_data, 8'hAA);
        rd_addr = 4'hF; #1; check("ram_f", rd_data, 8'h55);
        rd_addr = 4'h0; #1; check("ram_0_wrap", rd_data, 8'h11);

        // Foreign address: no ACK, command ignored
        txq = '{8'h20};
        do_write(7'h71);
        check("foreign_osc", osc_on, 1'b1);

        // Pointer set, repeated START, read two bytes
        do_read(2, 1'b1, 4'hE);
        check("rd0", rxq[0], 8'hAA);
        check("rd1", rxq[1], 8'h55);

        // Reset during the 4th data bit of a write
        start_cond();
        write_byte({Addr, 1'b0}, ack);
        check("mid_addr_ack", ack, 1'b1);
        write_byte(8'h00, ack);
        check("mid_ptr_ack", ack, 1'b1);
        m_ptr = 4'd0;
        m_stb++;
        for (int i = 0; i < 3; i++) write_bit(1'b1);
        sda_m = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_sda", sda_oe, 1'b0);
        check("mid_rst_osc", osc_on, 1'b0);
        check("mid_rst_disp", disp_on, 1'b0);
        check("mid_rst_dim", dim, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        stop_cond();
        check_all();
        txq = '{8'h21};
        do_write(Addr);
        check("post_rst_osc", osc_on, 1'b1);

        // Reset while the target is driving ACK releases SDA without a clock edge
        start_cond();
        hdr = {Addr, 1'b0};
        for (int i = 7; i >= 0; i--) write_bit(hdr[i]);
        check("ack_driven", sda_oe, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_release", sda_oe, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        read_bit(b);
        check("post_rst_no_ack", b, 1'b1);
        write_byte(8'h21, ack);
        check("post_rst_ignored", ack, 1'b0);
        stop_cond();
        check_all();

        // Fill RAM with random data
        txq = '{8'h00};
        for (int i = 0; i < 16; i++) txq.push_back(8'($urandom));
        do_write(Addr);

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 5);
            txq.delete();
            case (kind)
                0: begin
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) txq.push_back(rand_cmd());
                    do_write(Addr);
                end
                1: begin
                    txq.push_back({4'h0, 4'($urandom)});
                    n = $urandom_range(1, 5);
                    for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
                    do_write(Addr);
                end
                2: do_read($urandom_range(1, 4), 1'b0, 4'd0);
                3: do_read($urandom_range(1, 4), 1'b1, 4'($urandom));
                4: begin
                    n = $urandom_range(1, 2);
                    for (int i = 0; i < n; i++) txq.push_back(rand_cmd());
                    do_write(Addr ^ 7'($urandom_range(1, 127)));
                end
                default: begin
                    p = 4'($urandom);
                    start_cond();
                    write_byte({Addr, 1'b0}, ack);
                    check("abort_addr_ack", ack, 1'b1);
                    write_byte({4'h0, p}, ack);
                    check("abort_ptr_ack", ack, 1'b1);
                    m_ptr = p;
                    m_stb++;
                    n = $urandom_range(1, 7);
                    d = 8'($urandom);
                    for (int i = 0; i < n; i++) write_bit(d[7-i]);
                    stop_cond();
                    check_all();
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
